// File: rtl/captouch_scanner.sv
// Multi-channel capacitive touch scanner: one shared rise-time engine, time-multiplexed
// across NUM_CH pads, with per-channel baseline calibration, debounce and timeout flag.
module captouch_scanner #(
  parameter int NUM_CH           = 4,
  parameter int CW               = 15,
  parameter int DISCHARGE_CYCLES = 10,
  parameter int THRESH_SHIFT     = 3,
  parameter int DEB_DEPTH        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              recal,
  input  logic [NUM_CH-1:0] cap_in,
  output logic [NUM_CH-1:0] cap_out,
  output logic [NUM_CH-1:0] cap_oe,
  output logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] fault,
  output logic              scan_done
);

  localparam int              CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic [CW-1:0]   DIS_LAST = CW'(DISCHARGE_CYCLES - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISCHARGE, S_MEASURE, S_UPDATE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic [CW-1:0]          sample_q, sample_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_CH-1:0]      sync_meta_q, sync_meta_d;
  logic [NUM_CH-1:0]      sync_q, sync_d;
  logic [NUM_CH-1:0]      cal_pending_q, cal_pending_d;
  logic [NUM_CH-1:0]      btn_q, btn_d;
  logic [NUM_CH-1:0]      fault_q, fault_d;
  logic [CW-1:0]          baseline_q [NUM_CH];
  logic [CW-1:0]          baseline_d [NUM_CH];
  logic [DEB_DEPTH-1:0]   deb_q [NUM_CH];
  logic [DEB_DEPTH-1:0]   deb_d [NUM_CH];

  logic [CW:0]            thresh;
  logic                   touch;

  // Threshold is computed one bit wider so baseline + margin can never wrap.
  always_comb begin
    thresh = {1'b0, baseline_q[ch_q]} + ({1'b0, baseline_q[ch_q]} >> THRESH_SHIFT);
    touch  = ({1'b0, sample_q} > thresh) && !timeout_q;
  end

  always_comb begin
    sync_meta_d   = cap_in;
    sync_d        = sync_meta_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    ch_d          = ch_q;
    sample_d      = sample_q;
    timeout_d     = timeout_q;
    cal_pending_d = cal_pending_q;
    btn_d         = btn_q;
    fault_d       = fault_q;
    baseline_d    = baseline_q;
    deb_d         = deb_q;
    cap_oe        = '1;
    scan_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en) state_d = S_DISCHARGE;
      end
      S_DISCHARGE: begin
        if (cnt_q == DIS_LAST) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        cap_oe[ch_q] = 1'b0;
        if (sync_q[ch_q]) begin
          sample_d  = cnt_q;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_UPDATE;
        end else if (cnt_q == CNT_MAX) begin
          sample_d  = CNT_MAX;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        if (cal_pending_q[ch_q]) begin
          baseline_d[ch_q]    = sample_q;
          cal_pending_d[ch_q] = 1'b0;
        end else begin
          deb_d[ch_q] = (deb_q[ch_q] << 1) | DEB_DEPTH'(touch);
          if (&deb_d[ch_q])       btn_d[ch_q] = 1'b1;
          else if (~|deb_d[ch_q]) btn_d[ch_q] = 1'b0;
        end
        fault_d[ch_q] = timeout_q;
        if (ch_q == CH_LAST) begin
          ch_d      = '0;
          scan_done = 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
        state_d = en ? S_DISCHARGE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A recal on the same cycle as UPDATE discards that sample: calibration stays pending.
    if (recal) begin
      cal_pending_d = '1;
      btn_d         = '0;
      fault_d       = '0;
      baseline_d    = baseline_q;
      for (int i = 0; i < NUM_CH; i++) deb_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ch_q          <= '0;
      sample_q      <= '0;
      timeout_q     <= 1'b0;
      sync_meta_q   <= '0;
      sync_q        <= '0;
      cal_pending_q <= '1;
      btn_q         <= '0;
      fault_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        baseline_q[i] <= '0;
        deb_q[i]      <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      sample_q      <= sample_d;
      timeout_q     <= timeout_d;
      sync_meta_q   <= sync_meta_d;
      sync_q        <= sync_d;
      cal_pending_q <= cal_pending_d;
      btn_q         <= btn_d;
      fault_q       <= fault_d;
      baseline_q    <= baseline_d;
      deb_q         <= deb_d;
    end
  end

  assign cap_out = '0;
  assign btn     = btn_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_captouch_scanner.sv
// Directed bench for captouch_scanner: a pad model turns a per-channel rise delay
// into a known measured sample, and each scan's btn/fault result is checked.
module tb_captouch_scanner;

  localparam int NCH = 2;
  localparam int CW  = 10;
  localparam int DC  = 10;
  localparam int TS  = 3;
  localparam int DD  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           recal;
  logic [NCH-1:0] cap_in;
  logic [NCH-1:0] cap_out;
  logic [NCH-1:0] cap_oe;
  logic [NCH-1:0] btn;
  logic [NCH-1:0] fault;
  logic           scan_done;

  int rdel [NCH] = '{39, 39};
  int rc   [NCH];
  int checks   = 0;
  int failures = 0;

  captouch_scanner #(
    .NUM_CH(NCH), .CW(CW), .DISCHARGE_CYCLES(DC), .THRESH_SHIFT(TS), .DEB_DEPTH(DD)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .recal(recal), .cap_in(cap_in),
    .cap_out(cap_out), .cap_oe(cap_oe), .btn(btn), .fault(fault), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Pad model: a released pad reads high rdel negedges after release, giving sample = rdel+1.
  initial begin
    cap_in = '0;
    for (int i = 0; i < NCH; i++) rc[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (cap_oe[i]) begin
          rc[i]     = 0;
          cap_in[i] = 1'b0;
        end else begin
          rc[i]     = rc[i] + 1;
          cap_in[i] = (rc[i] >= rdel[i]);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic set_sample(input int ch, input int s);
    rdel[ch] = s - 1;
  endtask

  // Waits for the end of a scan, then one more edge so the last UPDATE has landed.
  task automatic wait_scan(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk); #1;
      if (scan_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic count_to_scan(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      n++;
      if (scan_done) break;
    end
  endtask

  initial begin
    int pulses;
    int n;
    reset = 1'b0;
    en    = 1'b0;
    recal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cap_oe", 32'(cap_oe), 32'd3);
    check_val("rst_cap_out", 32'(cap_out), 32'd0);
    check_val("rst_btn", 32'(btn), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_scan_done", 32'(scan_done), 32'd0);

    reset  = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (scan_done) pulses++;
    end
    check_val("idle_pulses", 32'(pulses), 32'd0);
    check_val("idle_cap_oe", 32'(cap_oe), 32'd3);
    check_val("idle_btn", 32'(btn), 32'd0);

    // Calibration: 2 x (10 + 41 + 1) cycles to the first scan_done
    set_sample(0, 40);
    set_sample(1, 40);
    en = 1'b1;
    count_to_scan(n);
    check_val("cal_scan_cycles", 32'(n), 32'd104);
    @(posedge clk); #1;
    check_val("cal_btn", 32'(btn), 32'd0);
    check_val("cal_fault", 32'(fault), 32'd0);

    set_sample(1, 46);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("touch_scan");
      check_val("touch_btn", 32'(btn), (s == 4) ? 32'd2 : 32'd0);
    end

    set_sample(1, 45);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("release_scan");
      check_val("release_btn", 32'(btn), (s == 4) ? 32'd0 : 32'd2);
    end

    for (int s = 1; s <= 6; s++) begin
      set_sample(0, (s % 2 == 1) ? 46 : 40);
      wait_scan("jitter_scan");
      check_val("jitter_btn", 32'(btn), 32'd0);
    end

    set_sample(0, 45);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("edge45_scan");
      check_val("edge45_btn", 32'(btn), 32'd0);
    end

    set_sample(0, 46);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("ch0_touch_scan");
      check_val("ch0_touch_btn", 32'(btn), (s == 4) ? 32'd1 : 32'd0);
    end

    // Stuck pad: timeout raises fault and counts as no-touch
    rdel[0] = 1 << 30;
    for (int s = 1; s <= 4; s++) begin
      wait_scan("timeout_scan");
      check_val("timeout_fault", 32'(fault), 32'd1);
      check_val("timeout_btn", 32'(btn), (s == 4) ? 32'd0 : 32'd1);
    end
    set_sample(0, 40);
    wait_scan("restore_scan");
    check_val("restore_fault", 32'(fault), 32'd0);

    set_sample(1, 46);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("pre_recal_scan");
      check_val("pre_recal_btn", 32'(btn), (s == 4) ? 32'd2 : 32'd0);
    end

    // Recal mid ch1 measurement: ch1's 46 becomes its new baseline
    repeat (65) @(posedge clk);
    #1;
    check_val("recal_meas_oe", 32'(cap_oe), 32'd1);
    recal = 1'b1;
    @(posedge clk); #1;
    recal = 1'b0;
    check_val("recal_btn", 32'(btn), 32'd0);
    check_val("recal_fault", 32'(fault), 32'd0);
    wait_scan("recal_scan");
    check_val("recal_cal_btn", 32'(btn), 32'd0);

    set_sample(1, 51);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("newbase51_scan");
      check_val("newbase51_btn", 32'(btn), 32'd0);
    end
    set_sample(1, 52);
    for (int s = 1; s <= 4; s++) begin
      wait_scan("newbase52_scan");
      check_val("newbase52_btn", 32'(btn), (s == 4) ? 32'd2 : 32'd0);
    end

    // Drop en during ch0 measurement; resume should start at ch1
    repeat (20) @(posedge clk);
    #1;
    check_val("en_drop_meas_oe", 32'(cap_oe), 32'd2);
    en     = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (scan_done) pulses++;
    end
    check_val("en_drop_pulses", 32'(pulses), 32'd0);
    check_val("en_drop_cap_oe", 32'(cap_oe), 32'd3);
    en = 1'b1;
    count_to_scan(n);
    check_val("resume_cycles", 32'(n), 32'd64);
    check_val("resume_btn", 32'(btn), 32'd2);

    // Asynchronous reset in the middle of DISCHARGE
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("mid_rst_cap_oe", 32'(cap_oe), 32'd3);
    check_val("mid_rst_btn", 32'(btn), 32'd0);
    check_val("mid_rst_fault", 32'(fault), 32'd0);
    check_val("mid_rst_scan_done", 32'(scan_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
